microwave_cook_sequencer: RTL and testbench

Cook-cycle controller for the microwave subsystem. It sits between the debounced button pulses and door switch on one side, and the display, motor and buzzer controllers on the other. It owns the cook-time register, the 1-second countdown prescaler and the cook state machine. It also enforces the door interlock.

---
 rtl/microwave_cook_sequencer_if.sv | 23 ++
 rtl/microwave_cook_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_microwave_cook_sequencer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/microwave_cook_sequencer_if.sv
// Button/door inputs and display/motor/buzzer outputs of the cook sequencer.
interface microwave_cook_sequencer_if;
  logic        add_pulse;
  logic        sub_pulse;
  logic        start_pulse;
  logic        cancel_pulse;
  logic        door;
  logic [13:0] run_time;
  logic [2:0]  mode;
  logic        motor_en;
  logic        done_beep;
  logic        door_reject;

  modport master (
    output add_pulse, sub_pulse, start_pulse, cancel_pulse, door,
    input  run_time, mode, motor_en, done_beep, door_reject
  );

  modport slave (
    input  add_pulse, sub_pulse, start_pulse, cancel_pulse, door,
    output run_time, mode, motor_en, done_beep, door_reject
  );
endinterface

// File: rtl/microwave_cook_sequencer.sv
// Microwave cook sequencer: owns the cook-time register, the one-second
// countdown prescaler and the cook state machine, and enforces the door
// interlock. Per cycle only the highest-priority event that has an effect in
// the current state acts (cancel > door > start > tick > add > sub).
module microwave_cook_sequencer #(
  parameter int TICK_CYCLES = 100_000_000,
  parameter int STEP_SEC    = 30,
  parameter int MAX_SEC     = 5999,
  parameter int DONE_SEC    = 3
) (
  input logic                        clk,
  input logic                        reset,
  microwave_cook_sequencer_if.slave  bus
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int DW = (DONE_SEC > 1) ? $clog2(DONE_SEC) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [DW-1:0] DONE_LAST = DW'(DONE_SEC - 1);
  localparam logic [13:0]   STEP_T    = 14'(STEP_SEC);
  localparam logic [13:0]   MAX_T     = 14'(MAX_SEC);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Add one step with a 15-bit intermediate, clamped at the ceiling.
  function automatic logic [13:0] sat_add(input logic [13:0] cur);
    logic [14:0] sum;
    sum = {1'b0, cur} + {1'b0, STEP_T};
    if (sum > {1'b0, MAX_T}) begin
      sat_add = MAX_T;
    end else begin
      sat_add = sum[13:0];
    end
  endfunction

  // Remove one step, clamped at zero.
  function automatic logic [13:0] sat_sub(input logic [13:0] cur);
    if (cur > STEP_T) begin
      sat_sub = cur - STEP_T;
    end else begin
      sat_sub = 14'd0;
    end
  endfunction

  state_t         state_r, state_s;
  logic [13:0]    run_time_r, run_time_s;
  logic [PW-1:0]  presc_r, presc_s, presc_adv_s;
  logic [DW-1:0]  done_cnt_r, done_cnt_s;
  logic           motor_en_r, done_beep_r, door_reject_r;
  logic           done_beep_s, door_reject_s;
  logic           tick_s;
  logic [13:0]    add_val_s, sub_val_s;
  logic           any_pulse_s;

  assign tick_s      = (presc_r == TICK_LAST);
  assign presc_adv_s = tick_s ? {PW{1'b0}} : (presc_r + PW'(1));
  assign add_val_s   = sat_add(run_time_r);
  assign sub_val_s   = sat_sub(run_time_r);
  assign any_pulse_s = bus.add_pulse | bus.sub_pulse | bus.start_pulse | bus.cancel_pulse;

  // Next-state, cook time, prescaler and done-counter decisions.
  always_comb begin
    state_s       = state_r;
    run_time_s    = run_time_r;
    presc_s       = presc_r;
    done_cnt_s    = done_cnt_r;
    done_beep_s   = 1'b0;
    door_reject_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        presc_s = {PW{1'b0}};
        if (bus.add_pulse) begin
          run_time_s = STEP_T;
          state_s    = ST_SET;
        end else begin
          run_time_s = 14'd0;
        end
      end
      ST_SET: begin
        presc_s = {PW{1'b0}};
        if (bus.cancel_pulse) begin
          run_time_s = 14'd0;
          state_s    = ST_IDLE;
        end else if (bus.start_pulse) begin
          if (bus.door) begin
            door_reject_s = 1'b1;
          end else begin
            state_s = ST_RUN;
          end
        end else if (bus.add_pulse) begin
          run_time_s = add_val_s;
        end else if (bus.sub_pulse) begin
          run_time_s = sub_val_s;
          if (sub_val_s == 14'd0) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_SET;
          end
        end else begin
          state_s = ST_SET;
        end
      end
      ST_RUN: begin
        if (bus.cancel_pulse) begin
          run_time_s = 14'd0;
          presc_s    = {PW{1'b0}};
          state_s    = ST_IDLE;
        end else if (bus.door || bus.start_pulse) begin
          // Prescaler holds so the second in progress resumes where it left off.
          state_s = ST_PAUSE;
        end else if (tick_s) begin
          presc_s = presc_adv_s;
          if (run_time_r <= 14'd1) begin
            run_time_s  = 14'd0;
            done_cnt_s  = {DW{1'b0}};
            done_beep_s = 1'b1;
            state_s     = ST_DONE;
          end else begin
            run_time_s = run_time_r - 14'd1;
          end
        end else begin
          presc_s = presc_adv_s;
          if (bus.add_pulse) begin
            run_time_s = add_val_s;
          end else begin
            run_time_s = run_time_r;
          end
        end
      end
      ST_PAUSE: begin
        if (bus.cancel_pulse) begin
          run_time_s = 14'd0;
          presc_s    = {PW{1'b0}};
          state_s    = ST_IDLE;
        end else if (bus.start_pulse) begin
          if (bus.door) begin
            door_reject_s = 1'b1;
          end else begin
            state_s = ST_RUN;
          end
        end else if (bus.add_pulse) begin
          run_time_s = add_val_s;
        end else if (bus.sub_pulse) begin
          run_time_s = sub_val_s;
          if (sub_val_s == 14'd0) begin
            presc_s = {PW{1'b0}};
            state_s = ST_IDLE;
          end else begin
            state_s = ST_PAUSE;
          end
        end else begin
          state_s = ST_PAUSE;
        end
      end
      ST_DONE: begin
        run_time_s = 14'd0;
        if (any_pulse_s || bus.door) begin
          presc_s    = {PW{1'b0}};
          done_cnt_s = {DW{1'b0}};
          state_s    = ST_IDLE;
        end else if (tick_s) begin
          presc_s = presc_adv_s;
          if (done_cnt_r == DONE_LAST) begin
            presc_s    = {PW{1'b0}};
            done_cnt_s = {DW{1'b0}};
            state_s    = ST_IDLE;
          end else begin
            done_cnt_s = done_cnt_r + DW'(1);
          end
        end else begin
          presc_s = presc_adv_s;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        run_time_s = 14'd0;
        presc_s    = {PW{1'b0}};
        done_cnt_s = {DW{1'b0}};
      end
    endcase
  end

  // State, cook-time, prescaler and done-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      run_time_r <= 14'd0;
      presc_r    <= {PW{1'b0}};
      done_cnt_r <= {DW{1'b0}};
    end else begin
      state_r    <= state_s;
      run_time_r <= run_time_s;
      presc_r    <= presc_s;
      done_cnt_r <= done_cnt_s;
    end
  end

  // Registered motor enable and one-cycle status pulses, aligned with mode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      motor_en_r    <= 1'b0;
      done_beep_r   <= 1'b0;
      door_reject_r <= 1'b0;
    end else begin
      motor_en_r    <= (state_s == ST_RUN);
      done_beep_r   <= done_beep_s;
      door_reject_r <= door_reject_s;
    end
  end

  assign bus.mode        = state_r;
  assign bus.run_time    = run_time_r;
  assign bus.motor_en    = motor_en_r;
  assign bus.done_beep   = done_beep_r;
  assign bus.door_reject = door_reject_r;

endmodule

// File: tb/tb_microwave_cook_sequencer.sv
// Self-checking bench for microwave_cook_sequencer: a hand-computed vector
// table, directed multi-cycle sequences and a randomized run, all compared
// against an integer reference model of the cooking rules.
module tb_microwave_cook_sequencer;
  localparam int TC   = 4;
  localparam int STEP = 30;
  localparam int MAXS = 5999;
  localparam int DSEC = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;

  microwave_cook_sequencer_if dut_if();

  microwave_cook_sequencer #(
    .TICK_CYCLES(TC), .STEP_SEC(STEP), .MAX_SEC(MAXS), .DONE_SEC(DSEC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(dut_if)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  string tag = "init";

  // Reference model: mode 0..4, seconds left, cycles into current second, ticks spent in DONE.
  int m_mode, m_time, m_phase, m_dticks;
  bit m_beep, m_rej;

  typedef struct {
    bit a, s, st, c, d;
    int mode, rt;
    bit motor, beep, rej;
  } vec_t;
  vec_t tbl[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s actual=%0d required=%0d", tag, name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_time = 0; m_phase = 0; m_dticks = 0; m_beep = 0; m_rej = 0;
  endtask

  function automatic int add_sec(input int t);
    return (t + STEP > MAXS) ? MAXS : t + STEP;
  endfunction

  function automatic int sub_sec(input int t);
    return (t > STEP) ? t - STEP : 0;
  endfunction

  // One clock of the cooking rules; phase is a cycle count modulo one second.
  task automatic model_step(input bit a, input bit s, input bit st, input bit c, input bit d);
    bit second_up;
    second_up = (m_phase == TC - 1);
    m_beep = 0;
    m_rej  = 0;
    case (m_mode)
      0: if (a) begin m_time = STEP; m_mode = 1; end
      1, 3: begin
        if (c) begin m_time = 0; m_mode = 0; end
        else if (st) begin
          if (d) m_rej = 1;
          else begin
            m_mode = 2;
            if (m_mode == 1) m_phase = 0;
          end
        end
        else if (a) m_time = add_sec(m_time);
        else if (s) begin m_time = sub_sec(m_time); if (m_time == 0) m_mode = 0; end
      end
      2: begin
        if (c) begin m_time = 0; m_mode = 0; end
        else if (d || st) m_mode = 3;
        else begin
          m_phase = (m_phase + 1) % TC;
          if (second_up) begin
            m_time = m_time - 1;
            if (m_time == 0) begin m_mode = 4; m_beep = 1; m_dticks = 0; end
          end
          else if (a) m_time = add_sec(m_time);
        end
      end
      4: begin
        if (a || s || st || c || d) m_mode = 0;
        else begin
          m_phase = (m_phase + 1) % TC;
          if (second_up) begin
            m_dticks++;
            if (m_dticks == DSEC) m_mode = 0;
          end
        end
      end
      default: m_mode = 0;
    endcase
    if (m_mode == 0 || m_mode == 1) m_phase = 0;
  endtask

  // Apply one cycle of inputs and compare every output with the model.
  task automatic cycle(input bit a, input bit s, input bit st, input bit c, input bit d);
    @(negedge clk);
    dut_if.add_pulse = a; dut_if.sub_pulse = s; dut_if.start_pulse = st;
    dut_if.cancel_pulse = c; dut_if.door = d;
    @(posedge clk);
    model_step(a, s, st, c, d);
    #1;
    check("mdl_mode", dut_if.mode, m_mode);
    check("mdl_time", dut_if.run_time, m_time);
    check("mdl_motor", dut_if.motor_en, (m_mode == 2) ? 1 : 0);
    check("mdl_beep", dut_if.done_beep, m_beep);
    check("mdl_reject", dut_if.door_reject, m_rej);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_mode"}, dut_if.mode, 0);
    check({pfx, "_time"}, dut_if.run_time, 0);
    check({pfx, "_motor"}, dut_if.motor_en, 0);
    check({pfx, "_beep"}, dut_if.done_beep, 0);
    check({pfx, "_reject"}, dut_if.door_reject, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    dut_if.add_pulse = 0; dut_if.sub_pulse = 0; dut_if.start_pulse = 0;
    dut_if.cancel_pulse = 0; dut_if.door = 0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("rst");
  endtask

  task automatic setv(input int i, input bit a, input bit s, input bit st, input bit c, input bit d,
                      input int mode, input int rt, input bit motor, input bit beep, input bit rej);
    tbl[i] = '{a, s, st, c, d, mode, rt, motor, beep, rej};
  endtask

  initial begin
    int n;
    int saved;
    bit door_lv;

    dut_if.add_pulse = 0; dut_if.sub_pulse = 0; dut_if.start_pulse = 0;
    dut_if.cancel_pulse = 0; dut_if.door = 0;

    //      idx a  s  st c  d   mode rt  mot beep rej
    setv( 0, 1, 0, 0, 0, 0,   1,  30, 0, 0, 0);
    setv( 1, 1, 0, 0, 0, 0,   1,  60, 0, 0, 0);
    setv( 2, 0, 1, 0, 0, 0,   1,  30, 0, 0, 0);
    setv( 3, 0, 0, 1, 0, 1,   1,  30, 0, 0, 1);
    setv( 4, 1, 0, 0, 0, 1,   1,  60, 0, 0, 0);
    setv( 5, 1, 0, 0, 1, 0,   0,   0, 0, 0, 0);
    setv( 6, 0, 0, 1, 0, 0,   0,   0, 0, 0, 0);
    setv( 7, 0, 1, 0, 0, 0,   0,   0, 0, 0, 0);
    setv( 8, 1, 0, 0, 0, 0,   1,  30, 0, 0, 0);
    setv( 9, 0, 0, 1, 0, 0,   2,  30, 1, 0, 0);
    setv(10, 0, 0, 0, 0, 0,   2,  30, 1, 0, 0);
    setv(11, 0, 0, 0, 0, 0,   2,  30, 1, 0, 0);
    setv(12, 0, 0, 0, 0, 0,   2,  30, 1, 0, 0);
    setv(13, 0, 0, 0, 0, 0,   2,  29, 1, 0, 0);
    setv(14, 1, 0, 0, 0, 0,   2,  59, 1, 0, 0);
    setv(15, 0, 0, 1, 0, 0,   3,  59, 0, 0, 0);
    setv(16, 1, 0, 0, 0, 0,   3,  89, 0, 0, 0);
    setv(17, 0, 1, 0, 0, 0,   3,  59, 0, 0, 0);
    setv(18, 0, 0, 1, 0, 1,   3,  59, 0, 0, 1);
    setv(19, 0, 0, 1, 0, 0,   2,  59, 1, 0, 0);
    setv(20, 0, 0, 0, 0, 0,   2,  59, 1, 0, 0);
    setv(21, 0, 0, 0, 0, 0,   2,  59, 1, 0, 0);
    setv(22, 0, 0, 0, 0, 0,   2,  58, 1, 0, 0);
    setv(23, 0, 0, 0, 1, 0,   0,   0, 0, 0, 0);

    tag = "reset";
    do_reset();

    tag = "table";
    for (int i = 0; i < 24; i++) begin
      cycle(tbl[i].a, tbl[i].s, tbl[i].st, tbl[i].c, tbl[i].d);
      check($sformatf("v%0d_mode", i), dut_if.mode, tbl[i].mode);
      check($sformatf("v%0d_time", i), dut_if.run_time, tbl[i].rt);
      check($sformatf("v%0d_motor", i), dut_if.motor_en, tbl[i].motor);
      check($sformatf("v%0d_beep", i), dut_if.done_beep, tbl[i].beep);
      check($sformatf("v%0d_reject", i), dut_if.door_reject, tbl[i].rej);
    end

    // Full 60 s cook to DONE, then automatic return to IDLE.
    tag = "cook60";
    do_reset();
    cycle(1, 0, 0, 0, 0); cycle(1, 0, 0, 0, 0); cycle(0, 0, 1, 0, 0);
    check("start_time", dut_if.run_time, 60);
    check("start_mode", dut_if.mode, 2);
    n = 0;
    while (dut_if.mode != 3'd4 && n < 400) begin cycle(0, 0, 0, 0, 0); n++; end
    check("run_cycles", n, 240);
    check("beep_first", dut_if.done_beep, 1);
    check("motor_off", dut_if.motor_en, 0);
    cycle(0, 0, 0, 0, 0);
    check("beep_once", dut_if.done_beep, 0);
    n = 1;
    while (dut_if.mode != 3'd0 && n < 100) begin cycle(0, 0, 0, 0, 0); n++; end
    check("done_cycles", n, 12);

    // Door open mid-cook freezes the time; resume keeps prescaler phase.
    tag = "door45";
    do_reset();
    cycle(1, 0, 0, 0, 0); cycle(1, 0, 0, 0, 0); cycle(0, 0, 1, 0, 0);
    idle(62);
    check("at45", dut_if.run_time, 45);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1);
    check("pause_mode", dut_if.mode, 3);
    check("pause_time", dut_if.run_time, 45);
    check("pause_motor", dut_if.motor_en, 0);
    cycle(0, 0, 1, 0, 0);
    check("resume_mode", dut_if.mode, 2);
    n = 0;
    while (dut_if.run_time == 14'd45 && n < 20) begin cycle(0, 0, 0, 0, 0); n++; end
    check("resume_phase", n, 2);

    // Door opens on the tick cycle: no decrement, tick fires right after resume.
    tag = "door_tick";
    n = 0;
    while (m_phase != TC - 1 && n < 10) begin cycle(0, 0, 0, 0, 0); n++; end
    saved = m_time;
    cycle(0, 0, 0, 0, 1);
    check("tick_pause_mode", dut_if.mode, 3);
    check("tick_pause_time", dut_if.run_time, saved);
    cycle(0, 0, 1, 0, 0);
    check("tick_resume_time", dut_if.run_time, saved);
    cycle(0, 0, 0, 0, 0);
    check("tick_first_dec", dut_if.run_time, saved - 1);

    // Saturation at the ceiling and at zero.
    tag = "saturate";
    do_reset();
    for (int i = 0; i < 200; i++) cycle(1, 0, 0, 0, 0);
    check("max_time", dut_if.run_time, 5999);
    check("max_mode", dut_if.mode, 1);
    for (int i = 0; i < 200; i++) cycle(0, 1, 0, 0, 0);
    check("floor_time", dut_if.run_time, 0);
    check("floor_mode", dut_if.mode, 0);
    cycle(1, 0, 0, 0, 0); cycle(0, 1, 0, 0, 0);
    check("sub30_time", dut_if.run_time, 0);
    check("sub30_mode", dut_if.mode, 0);

    // Cancel + start on the final tick of a cook: cancel wins, no beep.
    tag = "cancel_tick";
    do_reset();
    cycle(1, 0, 0, 0, 0); cycle(0, 0, 1, 0, 0);
    n = 0;
    while (!(m_time == 1 && m_phase == TC - 1) && n < 200) begin cycle(0, 0, 0, 0, 0); n++; end
    check("reach_last_tick", (m_time == 1 && m_phase == TC - 1) ? 1 : 0, 1);
    cycle(0, 0, 1, 1, 0);
    check("cancel_mode", dut_if.mode, 0);
    check("cancel_time", dut_if.run_time, 0);
    check("cancel_beep", dut_if.done_beep, 0);
    idle(3);
    check("cancel_no_beep", dut_if.done_beep, 0);

    // Asynchronous reset mid-cook clears outputs before the next clock edge.
    tag = "async_rst";
    do_reset();
    cycle(1, 0, 0, 0, 0); cycle(0, 0, 1, 0, 0);
    idle(5);
    check("pre_motor", dut_if.motor_en, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_all_zero("async");
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Randomized pulses and door activity against the model.
    tag = "random";
    door_lv = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15, 0) == 0) door_lv = ~door_lv;
      cycle(($urandom_range(3, 0) == 0), ($urandom_range(7, 0) == 0),
            ($urandom_range(9, 0) == 0), ($urandom_range(39, 0) == 0), door_lv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
